// File: rtl/mul_unit_seq_if.sv
// Start/finish handshake bundle between the execute stage and
// the sequential multiplier.
interface mul_unit_seq_if #(
    parameter int length = 32
);
    logic [length-1:0] oper_a;
    logic [length-1:0] oper_b;
    logic [1:0]        funct3;
    logic              enable_mul;
    logic              mul_busy;
    logic [length-1:0] mul_o;
    logic              mul_finish;

    modport master (
        output oper_a, oper_b, funct3, enable_mul,
        input  mul_busy, mul_o, mul_finish
    );

    modport slave (
        input  oper_a, oper_b, funct3, enable_mul,
        output mul_busy, mul_o, mul_finish
    );
endinterface

// File: rtl/mul_unit_seq.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Magnitudes are multiplied unsigned and the product is sign-corrected.
module mul_unit_seq #(
    parameter int length = 32
) (
    input logic           clk,
    input logic           rst,
    mul_unit_seq_if.slave bus
);
    localparam int CW = $clog2(length + 1);
    localparam logic [CW-1:0] LAST = CW'(length - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          f3_q, f3_d;
    logic                neg_q, neg_d;
    logic [2*length-1:0] mcand_q, mcand_d;
    logic [length-1:0]   mplier_q, mplier_d;
    logic [2*length-1:0] acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                fin_q, fin_d;
    logic [length-1:0]   res_q, res_d;

    logic                sign_a, sign_b;
    logic [length-1:0]   mag_a, mag_b;
    logic [2*length-1:0] prod;

    // Only MULH/MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
    assign sign_a = (bus.funct3 == 2'b01 || bus.funct3 == 2'b10)
                    && bus.oper_a[length-1];
    assign sign_b = (bus.funct3 == 2'b01) && bus.oper_b[length-1];
    assign mag_a  = sign_a ? ('0 - bus.oper_a) : bus.oper_a;
    assign mag_b  = sign_b ? ('0 - bus.oper_b) : bus.oper_b;
    assign prod   = neg_q ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        fin_d    = 1'b0;
        res_d    = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.enable_mul) begin
                    f3_d     = bus.funct3;
                    neg_d    = sign_a ^ sign_b;
                    mcand_d  = {{length{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                res_d   = (f3_q == 2'b00) ? prod[length-1:0]
                                          : prod[2*length-1:length];
                fin_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            fin_q    <= fin_d;
            res_q    <= res_d;
        end
    end

    assign bus.mul_busy   = busy_q;
    assign bus.mul_finish = fin_q;
    assign bus.mul_o      = res_q;
endmodule

// File: tb/tb_mul_unit_seq.sv
// Scoreboard bench for mul_unit_seq: directed vectors, expected
// results queued at issue and checked by an independent monitor.
module tb_mul_unit_seq;
    typedef struct {
        logic [31:0] res;
        int          start;
        string       tag;
    } exp_t;

    logic clk;
    logic rst;
    mul_unit_seq_if #(.length(32)) bus();

    mul_unit_seq #(.length(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   fin_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (bus.mul_busy) busy_cnt <= busy_cnt + 1;

    // Monitor: pops an expectation on every finish pulse.
    always @(negedge clk) begin
        if (!rst && bus.mul_finish) begin
            fin_cyc = cyc;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_finish got=%h", bus.mul_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                total++;
                if (bus.mul_o !== e.res) begin
                    bad++;
                    $display("FAIL %s result got=%h want=%h",
                             e.tag, bus.mul_o, e.res);
                end
                total++;
                if (cyc - e.start != 33) begin
                    bad++;
                    $display("FAIL %s latency got=%0d want=33",
                             e.tag, cyc - e.start);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] f, input logic [31:0] r,
                         input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        bus.oper_a     = a;
        bus.oper_b     = b;
        bus.funct3     = f;
        bus.enable_mul = 1'b1;
        @(posedge clk);
        #1;
        e.res   = r;
        e.start = cyc;
        e.tag   = tag;
        sb.push_back(e);
        bus.enable_mul = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s timeout pending=%0d", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        rst            = 1'b1;
        bus.oper_a     = '0;
        bus.oper_b     = '0;
        bus.funct3     = '0;
        bus.enable_mul = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.mul_busy}, 32'd0);
        check("rst_fin", {31'd0, bus.mul_finish}, 32'd0);
        check("rst_out", bus.mul_o, 32'd0);
        rst = 1'b0;

        busy_cnt = 0;
        issue(32'd7, 32'hFFFFFFFD, 2'b00, 32'hFFFFFFEB, "mul_7_m3");
        drain("mul_7_m3");
        check("busy_len", busy_cnt, 32'd33);

        issue(32'h80000000, 32'h80000000, 2'b01, 32'h40000000, "mulh_min");
        drain("mulh_min");
        issue(32'h80000000, 32'h80000000, 2'b00, 32'h00000000, "mul_min");
        drain("mul_min");
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF, "mulhsu_m1");
        drain("mulhsu_m1");
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFE, "mulhu_max");
        drain("mulhu_max");
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001, "mul_max");
        drain("mul_max");

        // Back-to-back: enable held high across the first finish.
        @(posedge clk);
        #1;
        bus.oper_a     = 32'h12345678;
        bus.oper_b     = 32'h0;
        bus.funct3     = 2'b01;
        bus.enable_mul = 1'b1;
        @(posedge clk);
        #1;
        e.res   = 32'h0;
        e.start = cyc;
        e.tag   = "b2b_first";
        sb.push_back(e);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (bus.mul_finish) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                total++;
                bad++;
                $display("FAIL b2b_first timeout pending=%0d", sb.size());
            end
        end
        e.res   = 32'h0;
        e.start = cyc + 1;
        e.tag   = "b2b_second";
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.enable_mul = 1'b0;
        drain("b2b_second");

        // Stray start during CALC plus operand change must be ignored.
        issue(32'd3, 32'd5, 2'b00, 32'h0000000F, "stray");
        repeat (5) @(posedge clk);
        #1;
        bus.funct3     = 2'b11;
        bus.oper_a     = 32'd2;
        bus.oper_b     = 32'd2;
        bus.enable_mul = 1'b1;
        @(posedge clk);
        #1;
        bus.enable_mul = 1'b0;
        drain("stray");
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-calculation.
        issue(32'hFFFFFFFF, 32'h3, 2'b11, 32'h00000002, "aborted");
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus.mul_busy}, 32'd0);
        check("arst_fin", {31'd0, bus.mul_finish}, 32'd0);
        check("arst_out", bus.mul_o, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(32'h00010000, 32'h00010000, 2'b11, 32'h00000001, "mulhu_2p32");
        drain("mulhu_2p32");
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
